pe_mac_sa: RTL and testbench
============================

# pe_mac_sa

Parametrised, dual-mode systolic processing element that succeeds the fixed 8-bit PE. It is one cell of the systolic array grid. It supports two dataflows:
- **Weight-stationary (WS):** a weight is preloaded through a vertical shift chain, and each cell adds a*w to a partial sum flowing downward.
- **Output-stationary (OS):** the cell accumulates a*b locally and drains the result down the column on request.

All outputs are registered and use signed two's-complement arithmetic.

## Interface
Parameters:
- DATA_W, 8, operand width (a, b, weight)
- ACC_W, 20, partial-sum/accumulator width; must satisfy ACC_W >= 2*DATA_W

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- mode  in  1  0 = WS, 1 = OS
- drain  in  1  OS drain request, level-sensitive
- a_in  in  DATA_W  left operand
- a_valid_in  in  1  a_in valid
- a_out  out  DATA_W  a_in forwarded right
- a_valid_out  out  1  a_valid_in forwarded right
- b_in  in  DATA_W  top operand; weight in WS, streaming operand in OS
- b_valid_in  in  1  b_in valid; weight load strobe in WS
- b_out  out  DATA_W  current w_reg, feeding the cell below
- b_valid_out  out  1  b_valid_in forwarded down
- ps_in  in  ACC_W  partial sum / drain data from above
- ps_valid_in  in  1  ps_in valid
- ps_out  out  ACC_W  partial sum / drained accumulator
- ps_valid_out  out  1  ps_out valid
- sat  out  1  sticky saturation flag

## Operation
- **Registers:** w_reg (DATA_W), acc (ACC_W), state, plus all output registers.
- **Product:** prod = signed(DATA_W) x signed(DATA_W) giving 2*DATA_W bits, sign-extended to ACC_W.
- **Every cycle, both modes:**
  - a_out <= a_in, a_valid_out <= a_valid_in.
  - If b_valid_in: w_reg <= b_in.
  - b_out = w_reg; b_valid_out <= b_valid_in.
- **States:**
  - WS
  - OS_ACC
  - OS_DRAIN
- **WS state (mode=0):**
  - If a_valid_in && ps_valid_in: ps_out <= ps_in + a_in*w_reg, ps_valid_out <= 1.
  - Otherwise ps_valid_out <= 0 and ps_out holds.
  - The multiply uses w_reg from before any same-cycle load.
  - If mode=1: go to OS_ACC and set acc <= 0.
- **OS_ACC state:**
  - If a_valid_in && b_valid_in: acc <= acc + a_in*b_in.
  - ps_valid_out <= 0.
  - If drain: go to OS_DRAIN; ps_out <= acc (+prod if a product is valid this cycle); ps_valid_out <= 1; acc <= 0.
  - Else if mode=0: go to WS; acc is discarded.
- **OS_DRAIN state:**
  - ps_out <= ps_in, ps_valid_out <= ps_valid_in (forwards upstream results down the column).
  - Valid operands still accumulate into the cleared acc.
  - If drain=0: go to OS_ACC if mode=1, else WS.
- **Simultaneous mode=0 and drain in OS_ACC:** drain wins; the WS transition happens on exit from OS_DRAIN.
- **Overflow:** ps_in + prod and acc + prod are computed at ACC_W+1 bits, then reduced to ACC_W per the Configuration section.

## Timing
- Reset (asynchronous assert, synchronous release):
  - All outputs go to 0 and sat to 0.
  - w_reg = 0, acc = 0, state = WS.
  - Reset asserted mid-drain or mid-accumulate aborts the operation immediately, with no residual valid.
- Latency: 1 cycle from the input edge to every output.
- Throughput: 1 MAC per cycle; no stalls and no backpressure.
- Drain: this cell's accumulator appears on ps_out exactly 1 cycle after the first drain=1 edge. A column of N cells needs drain held for N cycles.
- WS weight preload for a column of N cells: present weights bottom-row-first on N consecutive b_valid_in cycles.

## Configuration
- PE_SAT_EN defined:
  - Any sum exceeding the signed ACC_W range clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - sat is set and stays high until reset.
- PE_SAT_EN undefined:
  - Sums wrap modulo 2^ACC_W.
  - sat is tied to 0.

## Structure
- Shared package pe_pkg holds:
  - the state enum (PE_WS, PE_OS_ACC, PE_OS_DRAIN)
  - the mode encodings
  - a sat_add function parametrised by width
- One sub-module: pe_mult, a signed DATA_W x DATA_W combinational multiplier, kept separate so it can later be swapped for a pipelined version.

## Test plan
All scenarios use DATA_W=8, ACC_W=20 unless stated.
1. **Reset:** drive reset=0 mid-cycle -> all outputs and sat are 0 immediately; after release with all valids 0, outputs stay 0.
2. **WS MAC:** b_in=0xFD (-3) with b_valid; then a_in=5 and ps_in=100, both valid -> next cycle ps_out=85, ps_valid_out=1; a_out=5.
3. **WS weight chain:** b_in=7, then 9, on consecutive b_valid cycles -> w_reg=9, b_out=9, and the cell below holds 7.
4. **OS accumulate and drain:**
   - mode=1, operand pairs (2,3), (4,5), (-1,6) -> drain=1 gives ps_out=20 valid.
   - Next cycle with ps_in=55 valid -> ps_out=55.
   - Drain with a simultaneous valid pair (1,1) on the drain cycle -> 21.
5. **Overflow (ACC_W=16):** accumulate 127*127 three times -> with PE_SAT_EN: acc=32767, sat=1; without: wrapped value 48387-65536=-17149, sat=0.
6. **Reset mid-drain:** assert reset during OS_DRAIN -> ps_valid_out=0 and state WS after release; mode=1 re-entry starts from acc=0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and helpers for the systolic processing element.
// State encoding, mode encodings and the saturating add used when PE_SAT_EN is defined.
package pe_pkg;

    typedef enum logic [1:0] {
        PE_WS       = 2'd0,
        PE_OS_ACC   = 2'd1,
        PE_OS_DRAIN = 2'd2
    } pe_state_e;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

    localparam int unsigned SUM_W = 64;

    // Add two sign-extended operands and clamp the result to the signed range of a w-bit word.
    function automatic logic signed [SUM_W-1:0] sat_add(
        input logic signed [SUM_W-1:0] x,
        input logic signed [SUM_W-1:0] y,
        input int unsigned             w
    );
        logic signed [SUM_W-1:0] s;
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        s  = x + y;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/pe_mult.sv
// Signed DATA_W x DATA_W combinational multiplier, kept separate so a pipelined
// version can be dropped in without touching the PE.
module pe_mult #(
    parameter int unsigned DATA_W = 8
) (
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    output logic signed [2*DATA_W-1:0] prod_c
);

    assign prod_c = a * b;

endmodule

// File: rtl/pe_mac_sa.sv
// Dual-mode (weight-stationary / output-stationary) systolic PE with registered outputs.
// Define PE_SAT_EN to clamp sums and raise the sticky sat flag; otherwise sums wrap.
module pe_mac_sa
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              drain,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_valid_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_valid_out,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_valid_in,
    output logic [DATA_W-1:0] b_out,
    output logic              b_valid_out,
    input  logic [ACC_W-1:0]  ps_in,
    input  logic              ps_valid_in,
    output logic [ACC_W-1:0]  ps_out,
    output logic              ps_valid_out,
    output logic              sat
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    pe_state_e                state_q, state_d;
    logic [DATA_W-1:0]        w_q;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [ACC_W-1:0]         ps_out_d;
    logic                     ps_valid_d;
    logic                     sat_q, sat_d;
    logic                     pair;

    logic [DATA_W-1:0]        mul_b;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [SUM_W-1:0]  prod_x, ps_x, acc_x;
    logic [ACC_W-1:0]         ps_sum, acc_sum;
    logic                     ps_ovf, acc_ovf;

    // WS multiplies by the stored weight (pre-load value); OS multiplies the streaming operands.
    assign mul_b = (state_q == PE_WS) ? w_q : b_in;

    pe_mult #(.DATA_W(DATA_W)) u_mult (
        .a      (a_in),
        .b      (mul_b),
        .prod_c (prod_c)
    );

    assign prod_x = SUM_W'(prod_c);
    assign ps_x   = SUM_W'($signed(ps_in));
    assign acc_x  = SUM_W'($signed(acc_q));

`ifdef PE_SAT_EN
    logic signed [SUM_W-1:0] ps_sat_x, acc_sat_x;

    assign ps_sat_x  = sat_add(ps_x, prod_x, ACC_W);
    assign acc_sat_x = sat_add(acc_x, prod_x, ACC_W);
    assign ps_sum    = ACC_W'(ps_sat_x);
    assign acc_sum   = ACC_W'(acc_sat_x);
    assign ps_ovf    = (ps_sat_x != (ps_x + prod_x));
    assign acc_ovf   = (acc_sat_x != (acc_x + prod_x));
`else
    assign ps_sum  = ACC_W'(ps_x + prod_x);
    assign acc_sum = ACC_W'(acc_x + prod_x);
    assign ps_ovf  = 1'b0;
    assign acc_ovf = 1'b0;
`endif

    assign pair  = a_valid_in && b_valid_in;
    assign b_out = w_q;
    assign sat   = sat_q;

    // Next-state and next-datapath values.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        ps_out_d   = ps_out;
        ps_valid_d = 1'b0;
        sat_d      = sat_q;
        case (state_q)
            PE_WS: begin
                if (a_valid_in && ps_valid_in) begin
                    ps_out_d   = ps_sum;
                    ps_valid_d = 1'b1;
                    sat_d      = sat_q | ps_ovf;
                end
                if (mode == MODE_OS) begin
                    state_d = PE_OS_ACC;
                    acc_d   = '0;
                end
            end
            PE_OS_ACC: begin
                if (pair) begin
                    acc_d = acc_sum;
                    sat_d = sat_q | acc_ovf;
                end
                // Drain takes priority over a simultaneous return to WS.
                if (drain) begin
                    state_d    = PE_OS_DRAIN;
                    ps_out_d   = pair ? acc_sum : acc_q;
                    ps_valid_d = 1'b1;
                    acc_d      = '0;
                end else if (mode == MODE_WS) begin
                    state_d = PE_WS;
                end
            end
            PE_OS_DRAIN: begin
                ps_out_d   = ps_in;
                ps_valid_d = ps_valid_in;
                if (pair) begin
                    acc_d = acc_sum;
                    sat_d = sat_q | acc_ovf;
                end
                if (!drain) begin
                    state_d = (mode == MODE_OS) ? PE_OS_ACC : PE_WS;
                end
            end
            default: begin
                state_d = PE_WS;
            end
        endcase
    end

    // State, weight, accumulator and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= PE_WS;
            w_q          <= '0;
            acc_q        <= '0;
            sat_q        <= 1'b0;
            a_out        <= '0;
            a_valid_out  <= 1'b0;
            b_valid_out  <= 1'b0;
            ps_out       <= '0;
            ps_valid_out <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            sat_q        <= sat_d;
            a_out        <= a_in;
            a_valid_out  <= a_valid_in;
            b_valid_out  <= b_valid_in;
            ps_out       <= ps_out_d;
            ps_valid_out <= ps_valid_d;
            if (b_valid_in) begin
                w_q <= b_in;
            end
        end
    end

endmodule

// File: tb/tb_pe_mac_sa.sv
// Scoreboard bench for pe_mac_sa: a behavioural model predicts each cycle's outputs,
// a negedge monitor compares them; honours PE_SAT_EN like the design.
module tb_pe_mac_sa;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode, drain;
    logic [DW-1:0] a_in, b_in, a_out, b_out;
    logic          a_valid_in, b_valid_in, a_valid_out, b_valid_out;
    logic [AW-1:0] ps_in, ps_out;
    logic          ps_valid_in, ps_valid_out, sat;

    pe_mac_sa #(.DATA_W(DW), .ACC_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .drain        (drain),
        .a_in         (a_in),
        .a_valid_in   (a_valid_in),
        .a_out        (a_out),
        .a_valid_out  (a_valid_out),
        .b_in         (b_in),
        .b_valid_in   (b_valid_in),
        .b_out        (b_out),
        .b_valid_out  (b_valid_out),
        .ps_in        (ps_in),
        .ps_valid_in  (ps_valid_in),
        .ps_out       (ps_out),
        .ps_valid_out (ps_valid_out),
        .sat          (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic          av;
        logic [DW-1:0] b;
        logic          bv;
        logic          pv;
        logic          s;
    } cyc_t;

    cyc_t   cyc_q[$];
    longint ps_q[$];
    int     checks = 0;
    int     errors = 0;

    // Reference model: phase 0 = weight-stationary, 1 = accumulating, 2 = draining.
    int     ph = 0;
    longint w = 0, acc = 0;
    bit     msat = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reduce an exact sum to the ACC_W result: clamp (sticky flag) or wrap.
    function automatic longint fix(input longint x);
        longint hi = (64'sd1 <<< (AW - 1)) - 1;
        longint lo = -(64'sd1 <<< (AW - 1));
        longint m  = 64'sd1 <<< AW;
        longint r;
        if (x <= hi && x >= lo) return x;
`ifdef PE_SAT_EN
        msat = 1'b1;
        return (x > hi) ? hi : lo;
`else
        r = (x - lo) % m;
        if (r < 0) r += m;
        return r + lo;
`endif
    endfunction

    task automatic cyc(input bit md, input bit dr, input int a, input bit av,
                       input int b, input bit bv, input longint ps, input bit pv);
        cyc_t   e;
        longint pa, pb, pss, s, ps_val;
        bit     ps_v;
        mode = md; drain = dr;
        a_in = DW'(a); a_valid_in = av;
        b_in = DW'(b); b_valid_in = bv;
        ps_in = AW'(ps); ps_valid_in = pv;
        pa  = longint'($signed(a_in));
        pb  = longint'($signed(b_in));
        pss = longint'($signed(ps_in));
        ps_v = 1'b0; ps_val = 0;
        case (ph)
            0: begin
                if (av && pv) begin ps_v = 1'b1; ps_val = fix(pss + pa * w); end
                if (md) begin ph = 1; acc = 0; end
            end
            1: begin
                s = (av && bv) ? fix(acc + pa * pb) : acc;
                if (dr) begin ps_v = 1'b1; ps_val = s; acc = 0; ph = 2; end
                else begin acc = s; if (!md) ph = 0; end
            end
            default: begin
                ps_v = pv; ps_val = pss;
                if (av && bv) acc = fix(acc + pa * pb);
                if (!dr) ph = md ? 1 : 0;
            end
        endcase
        if (bv) w = pb;
        e.a = a_in; e.av = av; e.b = DW'(w); e.bv = bv; e.pv = ps_v; e.s = msat;
        @(posedge clk);
        cyc_q.push_back(e);
        if (ps_v) ps_q.push_back(ps_val);
        #1;
    endtask

    task automatic idle_inputs();
        mode = 0; drain = 0; a_in = '0; a_valid_in = 0;
        b_in = '0; b_valid_in = 0; ps_in = '0; ps_valid_in = 0;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        cyc_q.delete(); ps_q.delete();
        ph = 0; w = 0; acc = 0; msat = 0;
        #1;
        chk("rst_ps_valid", ps_valid_out, 0);
        chk("rst_ps_out", ps_out, 0);
        chk("rst_a_out", a_out, 0);
        chk("rst_b_out", b_out, 0);
        chk("rst_sat", sat, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Monitor: per-cycle forwarding/flag checks plus the ps scoreboard on every valid.
    always @(negedge clk) begin
        cyc_t   e;
        longint exp_ps;
        if (reset) begin
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("a_out", a_out, e.a);
                chk("a_valid_out", a_valid_out, e.av);
                chk("b_out", b_out, e.b);
                chk("b_valid_out", b_valid_out, e.bv);
                chk("ps_valid_out", ps_valid_out, e.pv);
                chk("sat", sat, e.s);
            end
            if (ps_valid_out) begin
                if (ps_q.size() == 0) begin
                    chk("ps_unexpected", 1, 0);
                end else begin
                    exp_ps = ps_q.pop_front();
                    chk("ps_out", longint'($signed(ps_out)), exp_ps);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        bit md;
        int dr_left;
        reset = 1'b0;
        idle_inputs();
        #3;
        chk("init_ps_valid", ps_valid_out, 0);
        chk("init_sat", sat, 0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // WS MAC with a negative weight.
        cyc(0, 0, 0, 0, -3, 1, 0, 0);
        cyc(0, 0, 5, 1, 0, 0, 100, 1);
        chk("ws_mac_85", longint'($signed(ps_out)), 85);
        chk("ws_a_out", a_out, 5);

        // Weight chain: the cell below sees the first weight while this cell keeps the second.
        cyc(0, 0, 0, 0, 7, 1, 0, 0);
        chk("ws_chain_7", b_out, 7);
        cyc(0, 0, 0, 0, 9, 1, 0, 0);
        chk("ws_chain_9", b_out, 9);

        // OS accumulate, drain, forward, and drain with a same-cycle pair.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 2, 1, 3, 1, 0, 0);
        cyc(1, 0, 4, 1, 5, 1, 0, 0);
        cyc(1, 0, -1, 1, 6, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        chk("os_drain_20", longint'($signed(ps_out)), 20);
        cyc(1, 1, 0, 0, 0, 0, 55, 1);
        chk("os_fwd_55", longint'($signed(ps_out)), 55);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 4, 1, 5, 1, 0, 0);
        cyc(1, 1, 1, 1, 1, 1, 0, 0);
        chk("os_drain_21", longint'($signed(ps_out)), 21);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        // Overflow: three 127*127 products in a 16-bit accumulator.
        repeat (3) cyc(1, 0, 127, 1, 127, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
`ifdef PE_SAT_EN
        chk("ovf_value", longint'($signed(ps_out)), 32767);
        chk("ovf_sat", sat, 1);
`else
        chk("ovf_value", longint'($signed(ps_out)), -17149);
        chk("ovf_sat", sat, 0);
`endif

        // Reset during a drain, then WS with cleared weight and a fresh OS accumulation.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 3, 1, 3, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 12, 1);
        do_reset();
        cyc(0, 0, 4, 1, 0, 0, 50, 1);
        chk("post_rst_ws", longint'($signed(ps_out)), 50);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 2, 1, 2, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_os", longint'($signed(ps_out)), 4);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomised traffic across both dataflows.
        md = 0; dr_left = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) md = ~md;
            if (dr_left == 0 && $urandom_range(0, 9) == 0) dr_left = $urandom_range(1, 4);
            cyc(md, dr_left > 0, int'($urandom_range(0, 255)), 1'($urandom),
                int'($urandom_range(0, 255)), 1'($urandom),
                longint'($urandom_range(0, 65535)), 1'($urandom));
            if (dr_left > 0) dr_left--;
            if (i == 300) do_reset();
        end

        idle_inputs();
        @(negedge clk); #1;
        chk("cyc_q_drained", cyc_q.size(), 0);
        chk("ps_q_drained", ps_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
